// File: rtl/mem_ctrl_pkg.sv
// Shared memory-control definitions: load size encodings, writeback FSM states
// and the load alignment rule.
package mem_ctrl_pkg;

  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b10;
  localparam logic [1:0] LD_FULL = 2'b11;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WB       = 2'd2
  } state_e;

  // Offset is zero-extended to 3 bits, so on a 32-bit bus a full load checks like a word load
  function automatic logic ld_misaligned(input logic [1:0] size, input logic [2:0] ofs);
    logic mis;
    mis = 1'b0;
    case (size)
      LD_HALF: mis = ofs[0];
      LD_WORD: mis = |ofs[1:0];
      LD_FULL: mis = |ofs;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ld_extract.sv
// Field select from a RAM word plus sign/zero extension to the full data width.
module ld_extract
  import mem_ctrl_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned OFS_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        size,
  input  logic              sgn,
  input  logic [OFS_W-1:0]  ofs,
  output logic [DATA_W-1:0] result_c
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic              sign_bit;

  // Shift the addressed byte to bit 0, keep the field, fill the rest with sign or zeros
  always_comb begin
    shifted  = data >> {ofs, 3'b000};
    mask     = '1;
    sign_bit = shifted[DATA_W-1];
    case (size)
      LD_BYTE: begin
        mask     = DATA_W'(8'hFF);
        sign_bit = shifted[7];
      end
      LD_HALF: begin
        mask     = DATA_W'(16'hFFFF);
        sign_bit = shifted[15];
      end
      LD_WORD: begin
        mask     = DATA_W'(32'hFFFF_FFFF);
        sign_bit = shifted[31];
      end
      default: begin
        mask     = '1;
        sign_bit = shifted[DATA_W-1];
      end
    endcase
    result_c = (shifted & mask) | ((sgn && sign_bit) ? ~mask : '0);
  end

endmodule

// File: rtl/ldr_wb_select.sv
// Writeback select: passes ALU results or waits on a variable-latency RAM
// response, extracts the load field and registers the result with error flag.
module ldr_wb_select
  import mem_ctrl_pkg::*;
#(
  parameter  int unsigned DATA_W  = 32,
  parameter  int unsigned TIMEOUT = 15,
  localparam int unsigned OFS_W   = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              sel_mem,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  input  logic [OFS_W-1:0]  addr_lo,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [DATA_W-1:0] ram_data,
  input  logic              ram_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_valid,
  output logic              err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [OFS_W-1:0]  ofs_q, ofs_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_valid_q, wb_valid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] ext_data_c;
  logic              accept_c;

  ld_extract #(.DATA_W(DATA_W)) u_ld_extract (
    .data     (ram_data),
    .size     (size_q),
    .sgn      (sgn_q),
    .ofs      (ofs_q),
    .result_c (ext_data_c)
  );

  assign op_ready = (state_q != WAIT_MEM);
  assign accept_c = op_valid && op_ready;
  assign wb_data  = wb_data_q;
  assign wb_valid = wb_valid_q;
  assign err      = err_q;

  // Next-state, timeout counter and writeback values
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    ofs_d      = ofs_q;
    wb_data_d  = wb_data_q;
    wb_valid_d = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      WAIT_MEM: begin
        if (ram_valid) begin
          wb_data_d  = ext_data_c;
          wb_valid_d = 1'b1;
          state_d    = WB;
        end else if (cnt_q == CNT_LAST) begin
          wb_data_d  = '0;
          wb_valid_d = 1'b1;
          err_d      = 1'b1;
          state_d    = WB;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        if (accept_c) begin
          if (!sel_mem) begin
            wb_data_d  = alu_data;
            wb_valid_d = 1'b1;
            state_d    = WB;
          end else begin
            size_d = ld_size;
            sgn_d  = ld_signed;
            ofs_d  = addr_lo;
            if (ld_misaligned(ld_size, 3'(addr_lo))) begin
              wb_data_d  = '0;
              wb_valid_d = 1'b1;
              err_d      = 1'b1;
              state_d    = WB;
            end else begin
              cnt_d   = '0;
              state_d = WAIT_MEM;
            end
          end
        end
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      size_q     <= LD_BYTE;
      sgn_q      <= 1'b0;
      ofs_q      <= '0;
      wb_data_q  <= '0;
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      ofs_q      <= ofs_d;
      wb_data_q  <= wb_data_d;
      wb_valid_q <= wb_valid_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_ldr_wb_select.sv
// Bench for ldr_wb_select: a 32-bit and a 64-bit instance share one stimulus
// stream; expected strobes are queued per instance and checked on arrival.
module tb_ldr_wb_select;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, sel_mem, ld_signed, ram_valid;
  logic [1:0]  ld_size;
  logic [2:0]  addr_lo;
  logic [63:0] alu_data, ram_data;

  logic        op_ready32, wb_valid32, err32;
  logic [31:0] wb_data32;
  logic        op_ready64, wb_valid64, err64;
  logic [63:0] wb_data64;

  ldr_wb_select #(.DATA_W(32), .TIMEOUT(TO)) dut32 (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready32),
    .sel_mem(sel_mem), .ld_size(ld_size), .ld_signed(ld_signed),
    .addr_lo(addr_lo[1:0]), .alu_data(alu_data[31:0]), .ram_data(ram_data[31:0]),
    .ram_valid(ram_valid), .wb_data(wb_data32), .wb_valid(wb_valid32), .err(err32)
  );

  ldr_wb_select #(.DATA_W(64), .TIMEOUT(TO)) dut64 (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready64),
    .sel_mem(sel_mem), .ld_size(ld_size), .ld_signed(ld_signed),
    .addr_lo(addr_lo), .alu_data(alu_data), .ram_data(ram_data),
    .ram_valid(ram_valid), .wb_data(wb_data64), .wb_valid(wb_valid64), .err(err64)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          at;
  } exp_t;

  typedef struct {
    string       name;
    logic        mem;
    logic [1:0]  sz;
    logic        sgn;
    logic [2:0]  ofs;
    logic [63:0] alu;
    logic [63:0] ram;
    int          dly;
    logic [31:0] e32;
    logic        err32;
    logic [63:0] e64;
    logic        err64;
  } vec_t;

  exp_t q32[$];
  exp_t q64[$];
  vec_t vt[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bench-side alignment rule, written arithmetically
  function automatic bit mis(input int dw, input logic [1:0] sz, input logic [2:0] ofs);
    int o;
    int s;
    o = (dw == 32) ? (int'(ofs) % 4) : int'(ofs);
    s = (dw == 32 && sz == 2'd3) ? 2 : int'(sz);
    case (s)
      1:       return (o % 2) != 0;
      2:       return (o % 4) != 0;
      3:       return o != 0;
      default: return 1'b0;
    endcase
  endfunction

  // Cycles from the accept edge to the edge that registers the strobe
  function automatic int lat(input int dw, input vec_t v);
    if (!v.mem)                return 0;
    if (mis(dw, v.sz, v.ofs))  return 0;
    if (v.dly < int'(TO))      return v.dly + 1;
    return int'(TO);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input vec_t v);
    int   acc;
    exp_t e;
    chk({v.name, "_ready32"}, 64'(op_ready32), 64'd1);
    chk({v.name, "_ready64"}, 64'(op_ready64), 64'd1);
    op_valid  = 1'b1;
    sel_mem   = v.mem;
    ld_size   = v.sz;
    ld_signed = v.sgn;
    addr_lo   = v.ofs;
    alu_data  = v.alu;
    ram_data  = v.ram;
    ram_valid = 1'b0;
    step();
    acc = cyc;
    e.data = 64'(v.e32); e.err = v.err32; e.at = acc + lat(32, v);
    q32.push_back(e);
    e.data = v.e64;      e.err = v.err64; e.at = acc + lat(64, v);
    q64.push_back(e);
    op_valid = 1'b0;
    alu_data = '1;
    if (v.mem) begin
      if (v.dly > 0 && !mis(32, v.sz, v.ofs)) chk({v.name, "_busy32"}, 64'(op_ready32), 64'd0);
      if (v.dly > 0 && !mis(64, v.sz, v.ofs)) chk({v.name, "_busy64"}, 64'(op_ready64), 64'd0);
      repeat (v.dly) step();
      ram_valid = 1'b1;
      step();
      ram_valid = 1'b0;
      ram_data  = '1;
    end
    repeat (2) step();
  endtask

  // Scoreboard: every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (wb_valid32) begin
        if (q32.size() == 0) begin
          chk("dut32_unexpected_strobe", 64'd1, 64'd0);
        end else begin
          e = q32.pop_front();
          chk("dut32_wb_data", 64'(wb_data32), e.data);
          chk("dut32_err", 64'(err32), 64'(e.err));
          chk("dut32_strobe_cycle", 64'(cyc), 64'(e.at));
        end
      end else if (err32) begin
        chk("dut32_err_without_valid", 64'(err32), 64'd0);
      end
      if (wb_valid64) begin
        if (q64.size() == 0) begin
          chk("dut64_unexpected_strobe", 64'd1, 64'd0);
        end else begin
          e = q64.pop_front();
          chk("dut64_wb_data", wb_data64, e.data);
          chk("dut64_err", 64'(err64), 64'(e.err));
          chk("dut64_strobe_cycle", 64'(cyc), 64'(e.at));
        end
      end else if (err64) begin
        chk("dut64_err_without_valid", 64'(err64), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc;
    exp_t e;
    //       name        mem sz    sgn  ofs   alu                     ram                     dly e32           err e64                     err
    vt.push_back('{"alu64",    1'b0, 2'd0, 1'b0, 3'd0, 64'hDEADBEEF_12345678, 64'h0,                 0, 32'h12345678, 1'b0, 64'hDEADBEEF_12345678, 1'b0});
    vt.push_back('{"byte_s",   1'b1, 2'd0, 1'b1, 3'd2, 64'h0, 64'h00000000_41A54125,                 2, 32'hFFFFFFA5, 1'b0, 64'hFFFFFFFF_FFFFFFA5, 1'b0});
    vt.push_back('{"byte_u",   1'b1, 2'd0, 1'b0, 3'd2, 64'h0, 64'h00000000_41A54125,                 2, 32'h000000A5, 1'b0, 64'h00000000_000000A5, 1'b0});
    vt.push_back('{"half_s",   1'b1, 2'd1, 1'b1, 3'd2, 64'h0, 64'h00000000_8001C256,                 1, 32'hFFFF8001, 1'b0, 64'hFFFFFFFF_FFFF8001, 1'b0});
    vt.push_back('{"half_mis", 1'b1, 2'd1, 1'b1, 3'd1, 64'h0, 64'h00000000_8001C256,                 1, 32'h0,        1'b1, 64'h0,                 1'b1});
    vt.push_back('{"timeout",  1'b1, 2'd0, 1'b0, 3'd0, 64'h0, 64'h00000000_000000FF,                 4, 32'h0,        1'b1, 64'h0,                 1'b1});
    vt.push_back('{"last_cnt", 1'b1, 2'd2, 1'b0, 3'd0, 64'h0, 64'h00000000_CAFEF00D,                 3, 32'hCAFEF00D, 1'b0, 64'h00000000_CAFEF00D, 1'b0});
    vt.push_back('{"full",     1'b1, 2'd3, 1'b1, 3'd0, 64'h0, 64'h80000000_00000001,                 0, 32'h00000001, 1'b0, 64'h80000000_00000001, 1'b0});
    vt.push_back('{"word_hi",  1'b1, 2'd2, 1'b1, 3'd4, 64'h0, 64'h80000000_00000001,                 1, 32'h00000001, 1'b0, 64'hFFFFFFFF_80000000, 1'b0});
    vt.push_back('{"half_top", 1'b1, 2'd1, 1'b0, 3'd6, 64'h0, 64'hBEEF0000_00000000,                 2, 32'h0,        1'b0, 64'h00000000_0000BEEF, 1'b0});
    vt.push_back('{"byte_top", 1'b1, 2'd0, 1'b1, 3'd7, 64'h0, 64'h7F000000_80000000,                 1, 32'hFFFFFF80, 1'b0, 64'h00000000_0000007F, 1'b0});
    vt.push_back('{"full_of4", 1'b1, 2'd3, 1'b0, 3'd4, 64'h0, 64'h00000000_12345678,                 1, 32'h12345678, 1'b0, 64'h0,                 1'b1});
    vt.push_back('{"full_of2", 1'b1, 2'd3, 1'b0, 3'd2, 64'h0, 64'h00000000_12345678,                 1, 32'h0,        1'b1, 64'h0,                 1'b1});
    vt.push_back('{"word_mis", 1'b1, 2'd2, 1'b1, 3'd2, 64'h0, 64'h00000000_12345678,                 1, 32'h0,        1'b1, 64'h0,                 1'b1});
    vt.push_back('{"word_neg", 1'b1, 2'd2, 1'b1, 3'd0, 64'h0, 64'h00000000_FFFFFFFE,                 0, 32'hFFFFFFFE, 1'b0, 64'hFFFFFFFF_FFFFFFFE, 1'b0});

    reset = 1'b1; op_valid = 1'b0; sel_mem = 1'b0; ld_size = 2'd0; ld_signed = 1'b0;
    addr_lo = 3'd0; alu_data = '0; ram_data = '0; ram_valid = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_wb_data32", 64'(wb_data32), 64'd0);
    chk("rst_wb_data64", wb_data64, 64'd0);
    chk("rst_wb_valid32", 64'(wb_valid32), 64'd0);
    chk("rst_wb_valid64", 64'(wb_valid64), 64'd0);
    chk("rst_err32", 64'(err32), 64'd0);
    chk("rst_err64", 64'(err64), 64'd0);
    chk("rst_ready32", 64'(op_ready32), 64'd1);
    chk("rst_ready64", 64'(op_ready64), 64'd1);

    // Back-to-back ALU ops: strobes on consecutive cycles
    op_valid = 1'b1; sel_mem = 1'b0; alu_data = 64'h00000000_00000007;
    step();
    acc = cyc;
    e.data = 64'h7; e.err = 1'b0; e.at = acc;
    q32.push_back(e); q64.push_back(e);
    chk("b2b_ready32_in_wb", 64'(op_ready32), 64'd1);
    chk("b2b_ready64_in_wb", 64'(op_ready64), 64'd1);
    alu_data = 64'h00000000_83240324;
    step();
    e.data = 64'h83240324; e.at = acc + 1;
    q32.push_back(e); q64.push_back(e);
    op_valid = 1'b0; alu_data = '1;
    repeat (2) step();

    foreach (vt[i]) do_op(vt[i]);

    // Reset in the middle of a RAM wait discards the load
    op_valid = 1'b1; sel_mem = 1'b1; ld_size = 2'd0; ld_signed = 1'b0; addr_lo = 3'd0;
    ram_data = 64'h00000000_000000AA;
    step();
    op_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_ready32", 64'(op_ready32), 64'd1);
    chk("midrst_ready64", 64'(op_ready64), 64'd1);
    chk("midrst_valid32", 64'(wb_valid32), 64'd0);
    chk("midrst_valid64", 64'(wb_valid64), 64'd0);
    chk("midrst_data32", 64'(wb_data32), 64'd0);
    chk("midrst_data64", wb_data64, 64'd0);
    ram_valid = 1'b1;
    step();
    ram_valid = 1'b0;
    repeat (3) step();

    chk("q32_drained", 64'(q32.size()), 64'd0);
    chk("q64_drained", 64'(q64.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
